pe_pass_scheduler: RTL and testbench

Sequences one PE through a complete convolution pass. It accepts a pass descriptor, loads the PE configuration with a one-cycle `PE_en` pulse, and then gates the filter, ifmap, ipsum and opsum streams between the global-buffer ports and the PE in the order the PE consumes them. It counts every word transferred, enforces the per-phase word budgets, flags PE/stream protocol mismatches, and signals completion. It sits between the GLB stream ports and one PE instance inside the PE array.

---
 rtl/pe_pkg.sv | 64 ++++++
 rtl/phase_counter.sv | 29 ++
 rtl/pe_pass_scheduler.sv | 211 +++++++++++++++++++++
 tb/tb_pe_pass_scheduler.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared PE definitions: config field layout, stream width, pass FSM states and
// budget helpers used by the pass scheduler and the PE itself.
package pe_pkg;

    localparam int unsigned DATA_BITS   = 32;
    localparam int unsigned CONFIG_SIZE = 13;

    localparam int unsigned CFG_DW_BIT  = 12;
    localparam int unsigned CFG_R_LSB   = 10;
    localparam int unsigned CFG_R_W     = 2;
    localparam int unsigned CFG_U_BIT   = 9;
    localparam int unsigned CFG_P_LSB   = 7;
    localparam int unsigned CFG_P_W     = 2;
    localparam int unsigned CFG_F_LSB   = 2;
    localparam int unsigned CFG_F_W     = 5;
    localparam int unsigned CFG_Q_LSB   = 0;
    localparam int unsigned CFG_Q_W     = 2;

    localparam int unsigned WCNT_W      = 4;
    localparam int unsigned COL_W       = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FILTER,
        ST_IFMAP,
        ST_IPSUM,
        ST_OPSUM,
        ST_FIN
    } pass_state_e;

    // Fields hold value-1, so every decoded dimension is in 1..4.
    function automatic logic [2:0] cfg_r(input logic [CONFIG_SIZE-1:0] c);
        return {1'b0, c[CFG_R_LSB +: CFG_R_W]} + 3'd1;
    endfunction

    function automatic logic [2:0] cfg_u(input logic [CONFIG_SIZE-1:0] c);
        return {2'b00, c[CFG_U_BIT]} + 3'd1;
    endfunction

    function automatic logic [2:0] cfg_p(input logic [CONFIG_SIZE-1:0] c);
        return {1'b0, c[CFG_P_LSB +: CFG_P_W]} + 3'd1;
    endfunction

    function automatic logic [2:0] cfg_q(input logic [CONFIG_SIZE-1:0] c);
        return {1'b0, c[CFG_Q_LSB +: CFG_Q_W]} + 3'd1;
    endfunction

    function automatic logic [COL_W-1:0] cfg_f(input logic [CONFIG_SIZE-1:0] c);
        return c[CFG_F_LSB +: CFG_F_W];
    endfunction

    // p*R can reach 16; the word counter saturates at 15.
    function automatic logic [WCNT_W-1:0] filter_words(input logic [CONFIG_SIZE-1:0] c);
        logic [5:0] w_prod;
        w_prod = {3'b000, cfg_p(c)} * {3'b000, cfg_r(c)};
        return (w_prod > 6'd15) ? '1 : w_prod[WCNT_W-1:0];
    endfunction

    function automatic logic [WCNT_W-1:0] psum_words(input logic [CONFIG_SIZE-1:0] c);
        return c[CFG_DW_BIT] ? {1'b0, cfg_q(c)} : {1'b0, cfg_p(c)};
    endfunction

endpackage

// File: rtl/phase_counter.sv
// Loadable down-counter holding the remaining word budget of the active phase.
module phase_counter
    import pe_pkg::*;
#(
    parameter int unsigned WIDTH = WCNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/pe_pass_scheduler.sv
// Sequences one PE through a convolution pass: config load, then filter, and per
// column ifmap/ipsum/opsum streams, each gated by a word budget.
module pe_pass_scheduler #(
    parameter int unsigned DATA_BITS   = 32,
    parameter int unsigned CONFIG_SIZE = 13
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   start_ready,
    input  logic [CONFIG_SIZE-1:0] cfg,
    output logic [CONFIG_SIZE-1:0] pe_config,
    output logic                   pe_en,
    input  logic [DATA_BITS-1:0]   src_filter_data,
    input  logic                   src_filter_valid,
    output logic                   src_filter_ready,
    input  logic [DATA_BITS-1:0]   src_ifmap_data,
    input  logic                   src_ifmap_valid,
    output logic                   src_ifmap_ready,
    input  logic [DATA_BITS-1:0]   src_ipsum_data,
    input  logic                   src_ipsum_valid,
    output logic                   src_ipsum_ready,
    output logic [DATA_BITS-1:0]   pe_filter_data,
    output logic                   pe_filter_valid,
    input  logic                   pe_filter_ready,
    output logic [DATA_BITS-1:0]   pe_ifmap_data,
    output logic                   pe_ifmap_valid,
    input  logic                   pe_ifmap_ready,
    output logic [DATA_BITS-1:0]   pe_ipsum_data,
    output logic                   pe_ipsum_valid,
    input  logic                   pe_ipsum_ready,
    input  logic [DATA_BITS-1:0]   pe_opsum_data,
    input  logic                   pe_opsum_valid,
    output logic                   pe_opsum_ready,
    output logic [DATA_BITS-1:0]   dst_opsum_data,
    output logic                   dst_opsum_valid,
    input  logic                   dst_opsum_ready,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    import pe_pkg::*;

    pass_state_e            r_state;
    pass_state_e            w_next;
    logic [CONFIG_SIZE-1:0] r_cfg;
    logic [COL_W-1:0]       r_col;
    logic                   r_err;
    logic                   r_alive;

    logic                   w_load;
    logic [WCNT_W-1:0]      w_load_val;
    logic                   w_zero;
    logic                   w_open;
    logic                   w_xfer;
    logic                   w_start_xfer;
    logic                   w_after_load;
    logic                   w_proto_err;
    logic                   w_last_col;

    phase_counter #(.WIDTH(WCNT_W)) u_word_cnt (
        .i_clk      (clk),
        .i_rst_n    (rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (w_xfer),
        .o_zero     (w_zero)
    );

    assign w_open       = ~w_zero;
    assign start_ready  = r_alive && (r_state == ST_IDLE);
    assign w_start_xfer = start && start_ready;
    assign w_last_col   = (r_col == cfg_f(r_cfg));
    assign pe_config    = r_cfg;
    assign pe_en        = (r_state == ST_LOAD);
    assign busy         = (r_state != ST_IDLE);
    assign done         = (r_state == ST_FIN);
    assign err          = r_err;

    assign w_after_load = (r_state != ST_IDLE) && (r_state != ST_LOAD);
    assign w_proto_err  = w_after_load &&
                          ((pe_filter_ready && (r_state != ST_FILTER)) ||
                           (pe_ifmap_ready  && (r_state != ST_IFMAP))  ||
                           (pe_ipsum_ready  && (r_state != ST_IPSUM))  ||
                           (pe_opsum_valid  && (r_state != ST_OPSUM)));

    // Data is zeroed on inactive streams so every output reads 0 outside its phase.
    always_comb begin
        pe_filter_valid  = 1'b0;
        pe_filter_data   = '0;
        src_filter_ready = 1'b0;
        pe_ifmap_valid   = 1'b0;
        pe_ifmap_data    = '0;
        src_ifmap_ready  = 1'b0;
        pe_ipsum_valid   = 1'b0;
        pe_ipsum_data    = '0;
        src_ipsum_ready  = 1'b0;
        dst_opsum_valid  = 1'b0;
        dst_opsum_data   = '0;
        pe_opsum_ready   = 1'b0;
        w_xfer           = 1'b0;
        case (r_state)
            ST_FILTER: begin
                pe_filter_valid  = src_filter_valid & w_open;
                src_filter_ready = pe_filter_ready & w_open;
                pe_filter_data   = src_filter_data;
                w_xfer           = src_filter_valid & pe_filter_ready & w_open;
            end
            ST_IFMAP: begin
                pe_ifmap_valid   = src_ifmap_valid & w_open;
                src_ifmap_ready  = pe_ifmap_ready & w_open;
                pe_ifmap_data    = src_ifmap_data;
                w_xfer           = src_ifmap_valid & pe_ifmap_ready & w_open;
            end
            ST_IPSUM: begin
                pe_ipsum_valid   = src_ipsum_valid & w_open;
                src_ipsum_ready  = pe_ipsum_ready & w_open;
                pe_ipsum_data    = src_ipsum_data;
                w_xfer           = src_ipsum_valid & pe_ipsum_ready & w_open;
            end
            ST_OPSUM: begin
                dst_opsum_valid  = pe_opsum_valid & w_open;
                pe_opsum_ready   = dst_opsum_ready & w_open;
                dst_opsum_data   = pe_opsum_data;
                w_xfer           = pe_opsum_valid & dst_opsum_ready & w_open;
            end
            default: ;
        endcase
    end

    // Each phase exits once its budget reads zero; the next budget loads on that edge.
    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_load_val = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_xfer) begin
                    w_next = ST_LOAD;
                    w_load = 1'b1;
                end
            end
            ST_LOAD: begin
                w_next     = ST_FILTER;
                w_load     = 1'b1;
                w_load_val = filter_words(r_cfg);
            end
            ST_FILTER: begin
                if (w_zero) begin
                    w_next     = ST_IFMAP;
                    w_load     = 1'b1;
                    w_load_val = {1'b0, cfg_r(r_cfg)};
                end
            end
            ST_IFMAP: begin
                if (w_zero) begin
                    w_next     = ST_IPSUM;
                    w_load     = 1'b1;
                    w_load_val = psum_words(r_cfg);
                end
            end
            ST_IPSUM: begin
                if (w_zero) begin
                    w_next     = ST_OPSUM;
                    w_load     = 1'b1;
                    w_load_val = psum_words(r_cfg);
                end
            end
            ST_OPSUM: begin
                if (w_zero) begin
                    if (w_last_col) begin
                        w_next = ST_FIN;
                    end else begin
                        w_next     = ST_IFMAP;
                        w_load     = 1'b1;
                        w_load_val = {1'b0, cfg_u(r_cfg)};
                    end
                end
            end
            ST_FIN:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cfg   <= '0;
            r_col   <= '0;
            r_err   <= 1'b0;
            r_alive <= 1'b0;
        end else begin
            r_alive <= 1'b1;
            r_state <= w_next;
            if (w_start_xfer) begin
                r_cfg <= cfg;
                r_col <= '0;
                r_err <= 1'b0;
            end else begin
                if ((r_state == ST_OPSUM) && w_zero && !w_last_col && (r_col != '1)) begin
                    r_col <= r_col + 1'b1;
                end
                if (w_proto_err) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pe_pass_scheduler.sv
// Scoreboard bench for pe_pass_scheduler: expected words are queued per pass and a
// negedge monitor pops and compares every PE-side and destination transfer.
module tb_pe_pass_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start;
    logic        start_ready;
    logic [12:0] cfg;
    logic [12:0] pe_config;
    logic        pe_en;
    logic [31:0] src_filter_data, src_ifmap_data, src_ipsum_data;
    logic        src_filter_valid, src_ifmap_valid, src_ipsum_valid;
    logic        src_filter_ready, src_ifmap_ready, src_ipsum_ready;
    logic [31:0] pe_filter_data, pe_ifmap_data, pe_ipsum_data, pe_opsum_data;
    logic        pe_filter_valid, pe_ifmap_valid, pe_ipsum_valid, pe_opsum_valid;
    logic        pe_filter_ready, pe_ifmap_ready, pe_ipsum_ready, pe_opsum_ready;
    logic [31:0] dst_opsum_data;
    logic        dst_opsum_valid, dst_opsum_ready;
    logic        busy, done, err;

    always #5 clk = ~clk;

    pe_pass_scheduler #(.DATA_BITS(32), .CONFIG_SIZE(13)) dut (
        .clk(clk), .rst(rst), .start(start), .start_ready(start_ready), .cfg(cfg),
        .pe_config(pe_config), .pe_en(pe_en),
        .src_filter_data(src_filter_data), .src_filter_valid(src_filter_valid), .src_filter_ready(src_filter_ready),
        .src_ifmap_data(src_ifmap_data), .src_ifmap_valid(src_ifmap_valid), .src_ifmap_ready(src_ifmap_ready),
        .src_ipsum_data(src_ipsum_data), .src_ipsum_valid(src_ipsum_valid), .src_ipsum_ready(src_ipsum_ready),
        .pe_filter_data(pe_filter_data), .pe_filter_valid(pe_filter_valid), .pe_filter_ready(pe_filter_ready),
        .pe_ifmap_data(pe_ifmap_data), .pe_ifmap_valid(pe_ifmap_valid), .pe_ifmap_ready(pe_ifmap_ready),
        .pe_ipsum_data(pe_ipsum_data), .pe_ipsum_valid(pe_ipsum_valid), .pe_ipsum_ready(pe_ipsum_ready),
        .pe_opsum_data(pe_opsum_data), .pe_opsum_valid(pe_opsum_valid), .pe_opsum_ready(pe_opsum_ready),
        .dst_opsum_data(dst_opsum_data), .dst_opsum_valid(dst_opsum_valid), .dst_opsum_ready(dst_opsum_ready),
        .busy(busy), .done(done), .err(err)
    );

    typedef struct packed {
        logic [1:0]  tag;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned idx_f = 0, idx_i = 0, idx_p = 0, idx_o = 0;
    int unsigned exp_f = 0, exp_i = 0, exp_p = 0, exp_o = 0;
    int unsigned cnt_f = 0, cnt_i = 0, cnt_p = 0, cnt_o = 0;
    int unsigned n_done = 0, n_pen = 0;
    logic        bp = 1'b0;
    logic        force_ifmap = 1'b0;
    logic        hs_f, hs_i, hs_p, hs_o;
    logic [153:0] all_outs;

    // Well-behaved PE: ready whenever offered, opsum offered whenever accepted.
    assign pe_filter_ready = pe_filter_valid;
    assign pe_ifmap_ready  = pe_ifmap_valid | force_ifmap;
    assign pe_ipsum_ready  = pe_ipsum_valid;
    assign pe_opsum_valid  = pe_opsum_ready;

    assign src_filter_data = {8'hF1, idx_f[23:0]};
    assign src_ifmap_data  = {8'hA2, idx_i[23:0]};
    assign src_ipsum_data  = {8'h53, idx_p[23:0]};
    assign pe_opsum_data   = {8'h0C, idx_o[23:0]};

    assign all_outs = {start_ready, pe_en, busy, done, err, pe_config,
                       pe_filter_valid, pe_ifmap_valid, pe_ipsum_valid,
                       src_filter_ready, src_ifmap_ready, src_ipsum_ready,
                       pe_opsum_ready, dst_opsum_valid,
                       pe_filter_data, pe_ifmap_data, pe_ipsum_data, dst_opsum_data};

    localparam logic [12:0] CFG_A = {1'b0, 2'd2, 1'b0, 2'd1, 5'd2, 2'd2}; // p2 q3 R3 U1 F2
    localparam logic [12:0] CFG_B = {1'b1, 2'd2, 1'b1, 2'd0, 5'd1, 2'd3}; // dw q4 p1 R3 U2 F1

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic sb_check(input logic [1:0] tag, input logic [31:0] data);
        exp_t e;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL sb_word: got tag %0d data %h, required no transfer", tag, data);
        end else begin
            e = sb.pop_front();
            if ((e.tag !== tag) || (e.data !== data)) begin
                n_fail++;
                $display("FAIL sb_word: got tag %0d data %h, required tag %0d data %h",
                         tag, data, e.tag, e.data);
            end
        end
    endtask

    // Monitor: every PE-side / destination transfer is checked against the queue.
    always @(negedge clk) begin
        if (rst) begin
            if (pe_filter_valid && pe_filter_ready) begin sb_check(2'd0, pe_filter_data); cnt_f++; end
            if (pe_ifmap_valid && pe_ifmap_ready)   begin sb_check(2'd1, pe_ifmap_data);  cnt_i++; end
            if (pe_ipsum_valid && pe_ipsum_ready)   begin sb_check(2'd2, pe_ipsum_data);  cnt_p++; end
            if (dst_opsum_valid && dst_opsum_ready) begin sb_check(2'd3, dst_opsum_data); cnt_o++; end
            if (done)  n_done++;
            if (pe_en) n_pen++;
        end
    end

    // Source/PE data model: advance word indices after each accepted transfer.
    always @(negedge clk) begin
        hs_f = src_filter_valid && src_filter_ready;
        hs_i = src_ifmap_valid && src_ifmap_ready;
        hs_p = src_ipsum_valid && src_ipsum_ready;
        hs_o = pe_opsum_valid && pe_opsum_ready;
        @(posedge clk);
        #1;
        if (hs_f) idx_f++;
        if (hs_i) idx_i++;
        if (hs_p) idx_p++;
        if (hs_o) idx_o++;
        src_filter_valid = !bp || ($urandom_range(9) >= 3);
        src_ifmap_valid  = !bp || ($urandom_range(9) >= 3);
        src_ipsum_valid  = !bp || ($urandom_range(9) >= 3);
        dst_opsum_ready  = !bp || ($urandom_range(9) >= 3);
    end

    task automatic push_words(input logic [1:0] tag, input int unsigned n);
        for (int unsigned k = 0; k < n; k++) begin
            case (tag)
                2'd0: begin sb.push_back({tag, 8'hF1, exp_f[23:0]}); exp_f++; end
                2'd1: begin sb.push_back({tag, 8'hA2, exp_i[23:0]}); exp_i++; end
                2'd2: begin sb.push_back({tag, 8'h53, exp_p[23:0]}); exp_p++; end
                default: begin sb.push_back({tag, 8'h0C, exp_o[23:0]}); exp_o++; end
            endcase
        end
    endtask

    task automatic push_pass(input int unsigned p, q, r, u, f, input bit dw);
        push_words(2'd0, p * r);
        for (int unsigned c = 0; c <= f; c++) begin
            push_words(2'd1, (c == 0) ? r : u);
            push_words(2'd2, dw ? q : p);
            push_words(2'd3, dw ? q : p);
        end
    endtask

    task automatic wait_done(input string name);
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (done) return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL %s_done_timeout: got no done in 600 cycles, required a done pulse", name);
    endtask

    task automatic wait_pen(input string name);
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (pe_en) return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL %s_pe_en_timeout: got no pe_en in 600 cycles, required a pe_en pulse", name);
    endtask

    task automatic run_start(input logic [12:0] c);
        @(posedge clk);
        #1;
        cfg   = c;
        start = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (start_ready) break;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_pass(input string name, input logic [12:0] c,
                            input int unsigned p, q, r, u, f, input bit dw,
                            input int unsigned ef, ei, ep, eo, input bit exp_err);
        int unsigned bf, bi, bpc, bo, bd;
        bf = cnt_f; bi = cnt_i; bpc = cnt_p; bo = cnt_o; bd = n_done;
        push_pass(p, q, r, u, f, dw);
        run_start(c);
        @(negedge clk);
        check({name, "_pe_en"},     64'(pe_en),     64'd1);
        check({name, "_err_clear"}, 64'(err),       64'd0);
        check({name, "_pe_config"}, 64'(pe_config), 64'(c));
        wait_done(name);
        @(negedge clk);
        check({name, "_filter_cnt"}, 64'(cnt_f - bf),  64'(ef));
        check({name, "_ifmap_cnt"},  64'(cnt_i - bi),  64'(ei));
        check({name, "_ipsum_cnt"},  64'(cnt_p - bpc), 64'(ep));
        check({name, "_opsum_cnt"},  64'(cnt_o - bo),  64'(eo));
        check({name, "_done_cnt"},   64'(n_done - bd), 64'd1);
        check({name, "_err"},        64'(err),         64'(exp_err));
        check({name, "_sb_empty"},   64'(sb.size()),   64'd0);
        check({name, "_busy_low"},   64'(busy),        64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1);
    end

    initial begin
        int unsigned bd, bpen, bpc;
        start = 1'b0;
        cfg   = '0;
        src_filter_valid = 1'b1;
        src_ifmap_valid  = 1'b1;
        src_ipsum_valid  = 1'b1;
        dst_opsum_ready  = 1'b1;

        #1 rst = 1'b0;
        #2 check("reset_outputs", 64'($countones(all_outs)), 64'd0);
        @(posedge clk); @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk); @(negedge clk);
        check("start_ready_after_reset", 64'(start_ready), 64'd1);

        run_pass("dense",   CFG_A, 2, 3, 3, 1, 2, 1'b0, 6, 5, 6, 6, 1'b0);
        run_pass("dwise",   CFG_B, 1, 4, 3, 2, 1, 1'b1, 3, 5, 8, 8, 1'b0);

        bp = 1'b1;
        run_pass("backpr",  CFG_A, 2, 3, 3, 1, 2, 1'b0, 6, 5, 6, 6, 1'b0);
        bp = 1'b0;

        fork
            run_pass("proterr", CFG_A, 2, 3, 3, 1, 2, 1'b0, 6, 5, 6, 6, 1'b1);
            begin
                wait_pen("proterr_force");
                check("proterr_err_before", 64'(err), 64'd0);
                @(posedge clk); #1 force_ifmap = 1'b1;
                @(posedge clk); #1 force_ifmap = 1'b0;
            end
        join
        repeat (3) @(negedge clk);
        check("proterr_sticky", 64'(err), 64'd1);

        // Abort a pass during the second ipsum word of column 1.
        bd  = n_done;
        bpc = cnt_p;
        push_pass(2, 3, 3, 1, 2, 1'b0);
        run_start(CFG_A);
        for (int k = 0; k < 300; k++) begin
            @(posedge clk);
            if ((cnt_p - bpc) >= 3) break;
        end
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (pe_ipsum_valid && pe_ipsum_ready) break;
        end
        check("midpass_ipsum_words", 64'(cnt_p - bpc), 64'd3);
        #2 rst = 1'b0;
        #1 check("midpass_reset_outputs", 64'($countones(all_outs)), 64'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        exp_f = idx_f; exp_i = idx_i; exp_p = idx_p; exp_o = idx_o;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("midpass_no_done", 64'(n_done - bd), 64'd0);
        run_pass("fresh",   CFG_B, 1, 4, 3, 2, 1, 1'b1, 3, 5, 8, 8, 1'b0);

        // Start held high: one pass per IDLE entry, cfg changes while busy ignored.
        bd   = n_done;
        bpen = n_pen;
        push_pass(1, 4, 3, 2, 1, 1'b1);
        push_pass(1, 4, 3, 2, 1, 1'b1);
        @(posedge clk);
        #1 cfg = CFG_B;
        start = 1'b1;
        wait_pen("held_1");
        @(posedge clk);
        #1 cfg = 13'h1FFF;
        repeat (3) @(negedge clk);
        check("held_cfg_ignored", 64'(pe_config), 64'(CFG_B));
        check("held_start_ready_busy", 64'(start_ready), 64'd0);
        wait_done("held_1");
        cfg = CFG_B;
        wait_pen("held_2");
        @(posedge clk);
        #1 start = 1'b0;
        cfg = 13'h0AAA;
        @(negedge clk);
        check("held_cfg_ignored_2", 64'(pe_config), 64'(CFG_B));
        wait_done("held_2");
        repeat (4) @(negedge clk);
        check("held_pe_en_cnt", 64'(n_pen - bpen), 64'd2);
        check("held_done_cnt",  64'(n_done - bd),  64'd2);
        check("held_sb_empty",  64'(sb.size()),    64'd0);
        check("held_err",       64'(err),          64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
